frame_ingest_unit: RTL and testbench
====================================

// Module: frame_ingest_unit
// PURPOSE
//   Input stage directly upstream of the edge-detection pipeline. Accepts a raw pixel stream
//   (valid/ready, source start-of-frame marker), locks onto frame boundaries, and buffers pixels in a FIFO.
//   Tags every pixel with sof/eol/eof from row/column counters. Feeds the Gaussian stage with framed pixels.
// PARAMETERS
//   PIXEL_W     8   bits per pixel
//   IMG_W       64  pixels per line (>=2)
//   IMG_H       64  lines per frame (>=2)
//   FIFO_DEPTH  16  FIFO entries; power of 2, >=2
// PORTS
//   clk        in   1        single clock, rising edge
//   reset      in   1        synchronous, active-high
//   enable     in   1        1 = ingest frames; sampled only at frame boundaries
//   s_pixel    in   PIXEL_W  source pixel
//   s_sof      in   1        source marks first pixel of a frame
//   s_valid    in   1        source beat valid
//   s_ready    out  1        beat accepted when s_valid && s_ready
//   m_pixel    out  PIXEL_W  pixel to edge pipeline
//   m_sof      out  1        m_pixel is (row 0, col 0)
//   m_eol      out  1        m_pixel is col IMG_W-1
//   m_eof      out  1        m_pixel is (IMG_H-1, IMG_W-1)
//   m_valid    out  1        output beat valid
//   m_ready    in   1        downstream accepts when m_valid && m_ready
//   frame_done out  1        1-cycle pulse: last pixel of frame left the FIFO
//   err_sync   out  1        sticky: s_sof seen mid-frame; cleared only by reset
// BEHAVIOUR
//   Reset: state IDLE, FIFO empty, counters 0, all outputs 0 (s_ready=0, m_valid=0).
//   FSM:
//     IDLE      s_ready=0; enable=1 -> WAIT_SOF next cycle.
//     WAIT_SOF  s_ready=1; beats with s_sof=0 are discarded.
//               Beat with s_sof=1 is written as (0,0) -> STREAM.
//     STREAM    s_ready=!full (registered full, no bypass).
//               Each accepted beat is written and col advances; col wraps IMG_W-1->0 with row++.
//               Write of (IMG_H-1, IMG_W-1) -> DRAIN.
//     DRAIN     s_ready=0 until FIFO empty and the eof entry has been popped.
//               frame_done pulses on the pop of the eof entry.
//               Then -> WAIT_SOF if enable=1, else IDLE.
//   Mid-frame s_sof=1 in STREAM (position != (0,0)):
//     - err_sync<=1; the beat is written as a new (0,0) sof; counters restart.
//     - The truncated frame is not marked eof.
//   enable=0 during WAIT_SOF -> IDLE; enable=0 during STREAM/DRAIN has no effect until frame end.
//   FIFO entry = {eof,eol,sof,pixel}; first-word fall-through.
//     - m_valid=!empty; pop on m_valid && m_ready; m_* hold stable while m_valid && !m_ready.
//     - Latency: beat accepted at cycle N appears on m_* at N+1 earliest.
//   FIFO simultaneous push+pop:
//     - When full: pop only (s_ready=0).
//     - When empty: push only, entry visible next cycle.
//     - Otherwise: count unchanged.
//   Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; count is $clog2(FIFO_DEPTH)+1 bits.
//   Counters: col $clog2(IMG_W) bits, row $clog2(IMG_H) bits, unsigned; never exceed IMG-1.
// CONFIGURATION
//   FRAME_INGEST_STATS_EN defined:
//     - frame_count[15:0] out: +1 per frame_done, wraps 0xFFFF->0.
//     - drop_count[15:0] out: +1 per beat discarded in WAIT_SOF, saturates at 0xFFFF.
//     - Both reset to 0.
//   Not defined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//   edge_pkg holds: pixel_t (logic [PIXEL_W-1:0]), ingest_entry_t struct {eof,eol,sof,pixel},
//     ingest_state_t enum {IDLE,WAIT_SOF,STREAM,DRAIN}.
//   Sub-module sync_fifo (param WIDTH, DEPTH; push/pop/full/empty/count) holds the buffer.
//   FSM and counters stay in frame_ingest_unit.
// TESTING (IMG_W=4, IMG_H=2, FIFO_DEPTH=4 unless noted)
//   1 Reset mid-STREAM after 3 beats -> next cycle s_ready=0, m_valid=0, err_sync=0; state IDLE.
//   2 enable=1, source beats 0x11(sof=0), 0x22(sof=0), then 0x01(sof=1)..0x08, m_ready=1
//     -> out 0x01..0x08; sof on 0x01, eol on 0x04/0x08, eof on 0x08;
//     -> frame_done one cycle after 0x08 pops; drop_count=2 (STATS_EN).
//   3 m_ready=0, 8-beat frame -> s_ready drops after 4 accepts;
//     -> m_pixel holds 0x01 stable; release m_ready -> all 8 delivered in order, no loss.
//   4 s_sof=1 on 3rd beat of a frame -> err_sync=1 and stays 1;
//     -> that beat leaves with m_sof=1; no m_eof for the aborted frame.
//   5 enable=0 after 5th beat -> remaining 3 beats still accepted, frame_done pulses, state IDLE, s_ready=0.
//   6 Back-to-back frames with m_ready=1 throughout -> frame_count=2 (STATS_EN);
//     -> WAIT_SOF re-entered after DRAIN, no extra drops.

Source files
------------

// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared types for the frame ingest stage of the edge-detection pipeline
//
// Purpose: pixel, FIFO entry and ingest FSM state types used by frame_ingest_unit
//          and by downstream consumers of its framed pixel stream.
// Ports:   none (package)

package edge_pkg;

    localparam int PIXEL_W = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef struct packed {
        logic   eof;
        logic   eol;
        logic   sof;
        pixel_t pixel;
    } ingest_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        STREAM,
        DRAIN
    } ingest_state_t;

endpackage

// File: rtl/frame_ingest_unit_fifo.sv
// rtl/frame_ingest_unit_fifo.sv - first-word fall-through synchronous FIFO (module sync_fifo)
//
// Purpose: buffers tagged pixel entries between the source handshake and the edge pipeline.
// Ports:   clk, reset (sync, active-high)
//          push/wr_data   write side; push ignored while full
//          pop/rd_data    read side; rd_data shows the head entry whenever !empty
//          full/empty     derived from the registered occupancy count
//          count          number of stored entries ($clog2(DEPTH)+1 bits)

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Fall-through: head entry is read combinationally, so a push into an
    // empty FIFO becomes visible the cycle after it is written.
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/frame_ingest_unit.sv
// rtl/frame_ingest_unit.sv - frame-locking pixel ingest stage feeding the edge pipeline
//
// Purpose: locks onto source start-of-frame, tags each pixel with sof/eol/eof from
//          row/column counters and buffers entries in a fall-through FIFO.
// Build option: FRAME_INGEST_STATS_EN adds frame_count/drop_count outputs.
// Ports:   clk, reset (sync, active-high), enable (sampled at frame boundaries)
//          s_pixel/s_sof/s_valid/s_ready   source stream
//          m_pixel/m_sof/m_eol/m_eof/m_valid/m_ready   framed output stream
//          frame_done   one-cycle pulse after the eof entry is popped
//          err_sync     sticky flag, source sof seen mid-frame
//          frame_count/drop_count   (FRAME_INGEST_STATS_EN only) frame and dropped-beat counters

module frame_ingest_unit #(
    parameter int PIXEL_W    = 8,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PIXEL_W-1:0] s_pixel,
    input  logic               s_sof,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [PIXEL_W-1:0] m_pixel,
    output logic               m_sof,
    output logic               m_eol,
    output logic               m_eof,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               frame_done,
    output logic               err_sync
`ifdef FRAME_INGEST_STATS_EN
    ,
    output logic [15:0]        frame_count,
    output logic [15:0]        drop_count
`endif
);

    import edge_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int EW = PIXEL_W + 3;
    localparam int QW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    ingest_state_t   state_q;
    logic [CW-1:0]   col_q, col_d, wr_col;
    logic [RW-1:0]   row_q, row_d, wr_row;
    logic            err_sync_q;
    logic            frame_done_q;

    logic            fifo_full, fifo_empty;
    logic [QW-1:0]   fifo_count;
    logic [EW-1:0]   wr_entry, rd_entry;

    logic            accept, push, pop, pop_eof, mid_sof;
    logic            w_sof, w_eol, w_eof;

    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            WAIT_SOF: s_ready = 1'b1;
            STREAM:   s_ready = !fifo_full;
            default:  s_ready = 1'b0;
        endcase
    end

    assign accept = s_valid && s_ready;
    // In WAIT_SOF only a sof beat is kept; everything else is dropped.
    assign push   = accept && ((state_q == STREAM) || s_sof);
    // A source sof always lands at (0,0), which also resynchronises mid-frame.
    assign wr_col = s_sof ? '0 : col_q;
    assign wr_row = s_sof ? '0 : row_q;
    assign w_sof  = (wr_col == '0) && (wr_row == '0);
    assign w_eol  = (wr_col == COL_LAST);
    assign w_eof  = w_eol && (wr_row == ROW_LAST);
    assign mid_sof = accept && (state_q == STREAM) && s_sof && !((col_q == '0) && (row_q == '0));

    always_comb begin
        col_d = wr_col + CW'(1);
        row_d = wr_row;
        if (w_eol) begin
            col_d = '0;
            row_d = w_eof ? '0 : wr_row + RW'(1);
        end
    end

    assign wr_entry = {w_eof, w_eol, w_sof, s_pixel};

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign pop_eof = pop && rd_entry[PIXEL_W+2];
    assign m_pixel = rd_entry[PIXEL_W-1:0];
    assign m_sof   = rd_entry[PIXEL_W];
    assign m_eol   = rd_entry[PIXEL_W+1];
    assign m_eof   = rd_entry[PIXEL_W+2];

    assign frame_done = frame_done_q;
    assign err_sync   = err_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            err_sync_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= pop_eof;
            if (push) begin
                col_q <= col_d;
                row_q <= row_d;
            end
            if (mid_sof) begin
                err_sync_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (enable) state_q <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (push)         state_q <= STREAM;
                    else if (!enable) state_q <= IDLE;
                end
                STREAM: begin
                    if (push && w_eof) state_q <= DRAIN;
                end
                DRAIN: begin
                    // The eof entry is the last one written, so popping it
                    // with a single entry left means the frame has fully left.
                    if (pop_eof && (fifo_count == QW'(1))) begin
                        state_q <= enable ? WAIT_SOF : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FRAME_INGEST_STATS_EN
    logic [15:0] frame_count_q;
    logic [15:0] drop_count_q;

    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            if (frame_done_q) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (accept && (state_q == WAIT_SOF) && !s_sof && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_ingest_unit.sv
// tb/tb_frame_ingest_unit.sv - scoreboard bench for frame_ingest_unit

module tb_frame_ingest_unit;

    logic       clk = 1'b0;
    logic       reset, enable, s_sof, s_valid, m_ready;
    logic [7:0] s_pixel;
    logic       s_ready, m_sof, m_eol, m_eof, m_valid, frame_done, err_sync;
    logic [7:0] m_pixel;
`ifdef FRAME_INGEST_STATS_EN
    logic [15:0] frame_count, drop_count;
`endif

    always #5 clk = ~clk;

    frame_ingest_unit #(
        .PIXEL_W    (8),
        .IMG_W      (4),
        .IMG_H      (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .s_pixel    (s_pixel),
        .s_sof      (s_sof),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_pixel    (m_pixel),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_eof      (m_eof),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_done (frame_done),
        .err_sync   (err_sync)
`ifdef FRAME_INGEST_STATS_EN
        ,
        .frame_count(frame_count),
        .drop_count (drop_count)
`endif
    );

    int          n_checks = 0;
    int          n_err = 0;
    int          fd_pulses = 0;
    logic [10:0] exp_q[$];
    logic        fd_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented output beat against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                fd_pending = 1'b0;
            end else begin
                if (frame_done) fd_pulses++;
                if (fd_pending || frame_done) chk("frame_done", frame_done, fd_pending);
                fd_pending = 1'b0;
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_out: got %0h expected no beat", {m_eof, m_eol, m_sof, m_pixel});
                    end else begin
                        chk(m_ready ? "out_beat" : "out_hold", {m_eof, m_eol, m_sof, m_pixel}, exp_q[0]);
                        if (m_ready) begin
                            fd_pending = exp_q[0][10];
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // flg = {eof,eol,sof} expected on the output; keep=0 means the beat is dropped.
    task automatic send(input logic [7:0] pix, input logic sof, input logic keep, input logic [2:0] flg);
        bit done = 1'b0;
        s_pixel = pix;
        s_sof   = sof;
        s_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                done = 1'b1;
                if (keep) exp_q.push_back({flg, pix});
            end else begin
                @(posedge clk);
            end
        end
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: pixel %0h not accepted in 200 cycles", pix);
        end
    endtask

    task automatic send_frame(input logic [7:0] base, input int first, input int last);
        logic [2:0] flg_tab [8];
        flg_tab = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b110};
        for (int k = first; k <= last; k++) begin
            send(base + 8'(k), (k == 0), 1'b1, flg_tab[k]);
        end
    endtask

    task automatic drain();
        int i = 0;
        while ((exp_q.size() != 0 || m_valid) && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_pixel = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_err_sync", err_sync, 0);
        chk("rst_frame_done", frame_done, 0);
`ifdef FRAME_INGEST_STATS_EN
        chk("rst_frame_count", frame_count, 0);
        chk("rst_drop_count", drop_count, 0);
`endif
        @(posedge clk);
        #1;

        // 1: reset in the middle of a frame (after a mid-frame sof raised err_sync)
        enable = 1'b1;
        send(8'hA1, 1'b1, 1'b1, 3'b001);
        send(8'hA2, 1'b0, 1'b1, 3'b000);
        send(8'hA3, 1'b1, 1'b1, 3'b001);
        @(negedge clk);
        chk("t1_err_sync_set", err_sync, 1);
        enable = 1'b0;
        reset  = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t1_s_ready", s_ready, 0);
        chk("t1_m_valid", m_valid, 0);
        chk("t1_err_sync", err_sync, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t1_idle_s_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;

        // 2: two dropped beats, then a full frame
        enable  = 1'b1;
        m_ready = 1'b1;
        send(8'h11, 1'b0, 1'b0, 3'b000);
        send(8'h22, 1'b0, 1'b0, 3'b000);
        send_frame(8'h01, 0, 7);
        drain();
`ifdef FRAME_INGEST_STATS_EN
        chk("t2_drop_count", drop_count, 2);
        chk("t2_frame_count", frame_count, 1);
`endif

        // 3: backpressure fills the FIFO, head holds, then release
        m_ready = 1'b0;
        send_frame(8'h01, 0, 3);
        repeat (3) begin
            @(negedge clk);
            chk("t3_full_s_ready", s_ready, 0);
            chk("t3_hold_pixel", m_pixel, 8'h01);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send_frame(8'h01, 4, 7);
        drain();
        chk("t3_err_sync", err_sync, 0);

        // 4: sof on 3rd beat restarts the frame
        send(8'h31, 1'b1, 1'b1, 3'b001);
        send(8'h32, 1'b0, 1'b1, 3'b000);
        send(8'h33, 1'b1, 1'b1, 3'b001);
        send(8'h34, 1'b0, 1'b1, 3'b000);
        send(8'h35, 1'b0, 1'b1, 3'b000);
        send(8'h36, 1'b0, 1'b1, 3'b010);
        send(8'h37, 1'b0, 1'b1, 3'b000);
        send(8'h38, 1'b0, 1'b1, 3'b000);
        send(8'h39, 1'b0, 1'b1, 3'b000);
        send(8'h3A, 1'b0, 1'b1, 3'b110);
        drain();
        chk("t4_err_sync", err_sync, 1);

        // 5: enable dropped mid-frame, frame still completes, then IDLE
        send_frame(8'h41, 0, 4);
        enable = 1'b0;
        send_frame(8'h41, 5, 7);
        drain();
        repeat (2) begin
            @(negedge clk);
            chk("t5_idle_s_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;

        // 6: back-to-back frames
        enable = 1'b1;
        send_frame(8'h51, 0, 7);
        send_frame(8'h61, 0, 7);
        drain();
        chk("t6_err_sync_sticky", err_sync, 1);
        chk("t6_frame_done_pulses", fd_pulses, 6);
`ifdef FRAME_INGEST_STATS_EN
        chk("t6_frame_count", frame_count, 6);
        chk("t6_drop_count", drop_count, 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
